// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills the GPP16 instruction RAM.
// It assembles big-endian words, writes them to consecutive addresses and checks an 8-bit additive checksum.
module imem_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                MAX_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_cnt
);

  // state     | meaning
  // S_LEN_HI  | waiting for word-count high byte
  // S_LEN_LO  | waiting for word-count low byte, range check
  // S_DATA_HI | waiting for high byte of next word
  // S_DATA_LO | waiting for low byte, word written next cycle
  // S_CSUM    | waiting for checksum byte
  // S_DONE    | load good, core released one cycle later
  // S_ERR     | load failed, core held in reset
  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]  state;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [7:0]  sum;
  logic [15:0] words_left;
  logic [15:0] len;
  logic        accept;

  assign in_ready = (state != S_DONE) && (state != S_ERR);
  assign accept   = in_valid && in_ready;
  assign len      = {len_hi, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_HI;
      len_hi     <= 8'd0;
      data_hi    <= 8'd0;
      sum        <= 8'd0;
      words_left <= 16'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'd0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        // start beats any byte offered in the same cycle
        state    <= S_LEN_HI;
        sum      <= 8'd0;
        word_cnt <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_rst  <= 1'b1;
      end else begin
        if (state == S_DONE) cpu_rst <= 1'b0;
        if (accept) begin
          case (state)
            S_LEN_HI: begin
              len_hi <= in_data;
              sum    <= sum + in_data;
              state  <= S_LEN_LO;
            end
            S_LEN_LO: begin
              sum        <= sum + in_data;
              words_left <= len;
              if (len > 16'(MAX_WORDS)) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else if (len == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA_HI;
              end
            end
            S_DATA_HI: begin
              data_hi <= in_data;
              sum     <= sum + in_data;
              state   <= S_DATA_LO;
            end
            S_DATA_LO: begin
              // words_left is a down-counter; terminal count 1 means this is the last word
              sum        <= sum + in_data;
              mem_we     <= 1'b1;
              mem_wdata  <= {data_hi, in_data};
              mem_addr   <= BASE_ADDR + word_cnt;
              word_cnt   <= word_cnt + ADDR_W'(1);
              words_left <= words_left - 16'd1;
              state      <= (words_left == 16'd1) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM: begin
              if (in_data == sum) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 0x0100) share one byte stream
// and are compared against a frame-level model computed from byte positions and checksum arithmetic.
module tb_imem_loader;

  localparam int MAXW = 1024;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;

  logic        in_ready_a, mem_we_a, cpu_rst_a, done_a, err_a;
  logic [15:0] mem_addr_a, mem_wdata_a, word_cnt_a;
  logic        in_ready_b, mem_we_b, cpu_rst_b, done_b, err_b;
  logic [15:0] mem_addr_b, mem_wdata_b, word_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(16), .MAX_WORDS(MAXW), .BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a), .word_cnt(word_cnt_a));

  imem_loader #(.ADDR_W(16), .MAX_WORDS(MAXW), .BASE_ADDR(16'h0100)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b), .word_cnt(word_cnt_b));

  always @(posedge clk) begin
    if (mem_we_a) pulses_a++;
    if (mem_we_b) pulses_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_rdy_a"}, in_ready_a, 1);   chk({tag, "_rdy_b"}, in_ready_b, 1);
    chk({tag, "_we_a"}, mem_we_a, 0);      chk({tag, "_we_b"}, mem_we_b, 0);
    chk({tag, "_cpu_a"}, cpu_rst_a, 1);    chk({tag, "_cpu_b"}, cpu_rst_b, 1);
    chk({tag, "_done_a"}, done_a, 0);      chk({tag, "_done_b"}, done_b, 0);
    chk({tag, "_err_a"}, err_a, 0);        chk({tag, "_err_b"}, err_b, 0);
    chk({tag, "_wc_a"}, word_cnt_a, 0);    chk({tag, "_wc_b"}, word_cnt_b, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
    @(negedge clk);
    chk_idle_state("rst");
    chk("rst_addr_a", mem_addr_a, 0);  chk("rst_addr_b", mem_addr_b, 0);
    chk("rst_wd_a", mem_wdata_a, 0);   chk("rst_wd_b", mem_wdata_b, 0);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk_idle_state("start");
  endtask

  function automatic bq_t make_frame(input int n, input bit bad_csum);
    bq_t q;
    logic [15:0] nn;
    int s;
    nn = 16'(n);
    q.push_back(nn[15:8]);
    q.push_back(nn[7:0]);
    for (int k = 0; k < n; k++) begin
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
    end
    s = 0;
    foreach (q[j]) s += int'(q[j]);
    q.push_back(8'((s % 256) + (bad_csum ? 1 : 0)));
    return q;
  endfunction

  // Feeds up to nsend bytes of q; the model derives each byte's role from its position.
  task automatic send_frame(input bq_t q, input int nsend, input string tag);
    int n, flen, acc, k, s, exp_words;
    bit bad_len, exp_done;
    n = int'({q[0], q[1]});
    bad_len = (n > MAXW);
    flen = bad_len ? 2 : 2 * n + 3;
    acc = (nsend < flen) ? nsend : flen;
    pulses_a = 0; pulses_b = 0;
    for (int i = 0; i < acc; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(negedge clk);
      end
      chk({tag, "_rdy_a"}, in_ready_a, 1);
      chk({tag, "_rdy_b"}, in_ready_b, 1);
      in_valid = 1'b1; in_data = q[i];
      @(negedge clk);
      in_valid = 1'b0;
      if (!bad_len && i >= 3 && i < 2 + 2 * n && ((i - 2) % 2 == 1)) begin
        k = (i - 3) / 2;
        chk({tag, "_we_a"}, mem_we_a, 1);
        chk({tag, "_we_b"}, mem_we_b, 1);
        chk({tag, "_addr_a"}, mem_addr_a, 32'(k));
        chk({tag, "_addr_b"}, mem_addr_b, 32'(16'h0100 + 16'(k)));
        chk({tag, "_data_a"}, mem_wdata_a, {q[i-1], q[i]});
        chk({tag, "_data_b"}, mem_wdata_b, {q[i-1], q[i]});
        chk({tag, "_wc_a"}, word_cnt_a, 32'(k + 1));
      end else begin
        chk({tag, "_nowe_a"}, mem_we_a, 0);
        chk({tag, "_nowe_b"}, mem_we_b, 0);
      end
    end
    if (acc == flen) begin
      s = 0;
      for (int j = 0; j < flen - 1; j++) s += int'(q[j]);
      exp_done = !bad_len && (int'(q[flen-1]) == s % 256);
      exp_words = bad_len ? 0 : n;
      chk({tag, "_done_a"}, done_a, 32'(exp_done));  chk({tag, "_done_b"}, done_b, 32'(exp_done));
      chk({tag, "_err_a"}, err_a, 32'(!exp_done));   chk({tag, "_err_b"}, err_b, 32'(!exp_done));
      chk({tag, "_endrdy_a"}, in_ready_a, 0);       chk({tag, "_endrdy_b"}, in_ready_b, 0);
      chk({tag, "_cpu0_a"}, cpu_rst_a, 1);
      chk({tag, "_cpu0_b"}, cpu_rst_b, 1);
      repeat (3) begin
        in_valid = 1'b1; in_data = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, "_cpu1_a"}, cpu_rst_a, 32'(!exp_done));
      chk({tag, "_cpu1_b"}, cpu_rst_b, 32'(!exp_done));
      chk({tag, "_hold_a"}, done_a, 32'(exp_done));
      chk({tag, "_holdrdy_a"}, in_ready_a, 0);
      chk({tag, "_pulses_a"}, pulses_a, 32'(exp_words));
      chk({tag, "_pulses_b"}, pulses_b, 32'(exp_words));
      chk({tag, "_wcend_a"}, word_cnt_a, 32'(exp_words));
      chk({tag, "_wcend_b"}, word_cnt_b, 32'(exp_words));
    end
  endtask

  initial begin
    bq_t f1, f2, q;
    @(negedge clk);
    do_reset();

    f1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    send_frame(f1, 99, "t1");

    do_start();
    f2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    send_frame(f2, 99, "t2");

    do_start();
    q = '{8'h04, 8'h01};
    send_frame(q, 99, "t3");

    do_start();
    q = '{8'h00, 8'h00, 8'h00};
    send_frame(q, 99, "t4ok");
    do_start();
    q = '{8'h00, 8'h00, 8'h01};
    send_frame(q, 99, "t4bad");

    do_start();
    send_frame(f1, 4, "t5part");
    do_start();
    send_frame(f1, 99, "t5");

    do_start();
    send_frame(f1, 5, "t6part");
    do_reset();
    send_frame(f1, 99, "t6");

    for (int r = 0; r < 8; r++) begin
      do_start();
      send_frame(make_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0), 99, "rnd");
    end

    do_start();
    send_frame(make_frame(MAXW, 1'b0), 99, "max");
    do_start();
    send_frame(make_frame(MAXW + 1, 1'b0), 99, "over");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
